itype_commit_checker: RTL
=========================

ITYPE_COMMIT_CHECKER -- requirements
Module: itype_commit_checker

Interface
REQ-001 Parameter WORD_SIZE, default 32, datapath width.
REQ-002 Parameter NUM_REGS, default 32, shadow register count.
REQ-003 Parameter STOP_ON_ERR, default 1, 1 = enter FAIL on first mismatch.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 init_we  in  1  seed write strobe (INIT only).
REQ-007 init_idx  in  5  seed register index.
REQ-008 init_data  in  WORD_SIZE  seed value.
REQ-009 start  in  1  one-cycle pulse, INIT -> RUN.
REQ-010 commit_valid  in  1  core retires one instruction this cycle.
REQ-011 commit_instr  in  32  retired instruction word.
REQ-012 commit_rd  in  5  destination index written by core.
REQ-013 commit_wdata  in  WORD_SIZE  value written by core.
REQ-014 err_valid  out  1  one-cycle pulse per detected error.
REQ-015 err_code  out  2  0 data mismatch, 1 rd mismatch, 2 illegal encoding.
REQ-016 err_expected / err_actual  out  WORD_SIZE each  checker vs core value of the erroring commit.
REQ-017 commit_count  out  32  accepted commits in RUN.
REQ-018 error_count  out  16  errors detected, saturating at 16'hFFFF.
REQ-019 state  out  2  INIT=0, RUN=1, FAIL=2.

Function
REQ-020 FSM: INIT -> RUN on start; RUN -> FAIL on error when STOP_ON_ERR=1; FAIL held until reset; start ignored outside INIT.
REQ-021 In INIT, init_we writes init_data to shadow[init_idx]; index 0 write discarded; commit_valid ignored.
REQ-022 In RUN, commit_valid with opcode 7'b0010011 decodes funct3: 0 ADDI, 2 SLTI, 3 SLTIU, 4 XORI, 6 ORI, 7 ANDI, 1 SLLI, 5 SRLI/SRAI.
REQ-023 Immediate sign-extended from instr[31:20]; shift amount instr[24:20]; SLTI signed, SLTIU unsigned compare of sign-extended imm, result 0/1.
REQ-024 Illegal: opcode not 0010011, SLLI with imm[11:5] != 0, funct3 5 with imm[11:5] not 0 or 7'b0100000 (imm[10] selects SRAI) -> err_code 2, no shadow write.
REQ-025 commit_rd != instr[11:7] -> err_code 1, no shadow write.
REQ-026 rd = 0: no data check, shadow[0] stays 0; shadow index 0 reads 0 always.
REQ-027 Expected value computed combinationally from shadow in commit cycle; on that edge shadow[rd] <= expected (not core value), so back-to-back dependent commits see the updated value.
REQ-028 commit_wdata != expected (rd != 0) -> err_code 0.
REQ-029 One error max per commit; priority illegal > rd > data.
REQ-030 err_* outputs registered: valid one cycle after the commit edge; err_expected/err_actual hold until next error.
REQ-031 commit_count increments per RUN commit including erroring ones; wraps at 2^32.
REQ-032 In FAIL, commits ignored; counters and shadow frozen.

Reset
REQ-033 On reset: state INIT, shadow all zero, err_valid 0, err_code 0, err_expected 0, err_actual 0, commit_count 0, error_count 0.
REQ-034 reset mid-RUN or mid-FAIL discards any in-flight error pulse on that edge.

Structure
REQ-035 Shared package holds opcode/funct3 constants, err_code enum, state enum.
REQ-036 One sub-module itype_alu_ref: combinational expected-value and legality from instr and rs1 value.

Verification
REQ-037 Seed x1=32'h0000_0005, start, commit ADDI x2,x1,-1 with wdata 4 -> no err, commit_count 1.
REQ-038 ADDI x3,x2,3 immediately after with wdata 7 -> no err (dependent back-to-back).
REQ-039 SRAI x4,x5,4 with x5=32'h8000_0000, wdata 32'h0800_0000 -> err_valid next cycle, code 0, expected 32'hF800_0000, state FAIL.
REQ-040 STOP_ON_ERR=0, SLLI imm[11:5]=7'h01 -> code 2, error_count 1, state RUN, shadow unchanged.
REQ-041 ADDI x0,x0,0 with wdata 32'hDEAD_BEEF -> no err, shadow[0] = 0.
REQ-042 reset asserted in FAIL -> next cycle state INIT, counters 0.

Source files
------------

// File: rtl/itype_commit_checker_pkg.sv
// Shared constants and types for the I-type commit checker: opcode/funct3
// encodings, error codes and checker states.
package itype_commit_checker_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IDX_W   = 5;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'd0;
  localparam logic [2:0] F3_SLLI  = 3'd1;
  localparam logic [2:0] F3_SLTI  = 3'd2;
  localparam logic [2:0] F3_SLTIU = 3'd3;
  localparam logic [2:0] F3_XORI  = 3'd4;
  localparam logic [2:0] F3_SRXI  = 3'd5;
  localparam logic [2:0] F3_ORI   = 3'd6;
  localparam logic [2:0] F3_ANDI  = 3'd7;

  // Upper immediate bits allowed on shift encodings
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef enum logic [1:0] {
    ERR_DATA    = 2'd0,
    ERR_RD      = 2'd1,
    ERR_ILLEGAL = 2'd2
  } err_code_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

endpackage

// File: rtl/itype_commit_checker_alu.sv
// Reference model of the OP-IMM instruction group: computes the value the
// core should write and flags encodings that are not legal I-type ALU ops.
module itype_alu_ref
  import itype_commit_checker_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [11:0]          imm12,
  input  logic [WORD_SIZE-1:0] rs1_val,
  output logic [WORD_SIZE-1:0] result_c,
  output logic                 illegal_c
);

  logic [WORD_SIZE-1:0] imm_sext;
  logic [4:0]           shamt;

  always_comb begin
    imm_sext  = {{(WORD_SIZE-12){imm12[11]}}, imm12};
    shamt     = imm12[4:0];
    result_c  = '0;
    illegal_c = (opcode != OPC_OP_IMM);
    case (funct3)
      F3_ADDI:  result_c = rs1_val + imm_sext;
      F3_SLTI:  result_c = WORD_SIZE'($signed(rs1_val) < $signed(imm_sext));
      F3_SLTIU: result_c = WORD_SIZE'(rs1_val < imm_sext);
      F3_XORI:  result_c = rs1_val ^ imm_sext;
      F3_ORI:   result_c = rs1_val | imm_sext;
      F3_ANDI:  result_c = rs1_val & imm_sext;
      F3_SLLI: begin
        result_c = rs1_val << shamt;
        if (imm12[11:5] != F7_ZERO) illegal_c = 1'b1;
      end
      F3_SRXI: begin
        // imm[10] distinguishes arithmetic from logical right shift
        if (imm12[10]) result_c = WORD_SIZE'($signed(rs1_val) >>> shamt);
        else           result_c = rs1_val >> shamt;
        if ((imm12[11:5] != F7_ZERO) && (imm12[11:5] != F7_SRA)) illegal_c = 1'b1;
      end
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/itype_commit_checker.sv
// Lock-step commit checker: keeps a shadow register file, recomputes every
// retired I-type ALU instruction and reports the first (or every) divergence.
module itype_commit_checker
  import itype_commit_checker_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_we,
  input  logic [IDX_W-1:0]     init_idx,
  input  logic [WORD_SIZE-1:0] init_data,
  input  logic                 start,
  input  logic                 commit_valid,
  input  logic [INSTR_W-1:0]   commit_instr,
  input  logic [IDX_W-1:0]     commit_rd,
  input  logic [WORD_SIZE-1:0] commit_wdata,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic [WORD_SIZE-1:0] err_expected,
  output logic [WORD_SIZE-1:0] err_actual,
  output logic [31:0]          commit_count,
  output logic [15:0]          error_count,
  output logic [1:0]           state
);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] shadow_q [NUM_REGS];
  logic [WORD_SIZE-1:0] shadow_d [NUM_REGS];
  logic                 err_valid_q, err_valid_d;
  err_code_e            err_code_q, err_code_d;
  logic [WORD_SIZE-1:0] err_expected_q, err_expected_d;
  logic [WORD_SIZE-1:0] err_actual_q, err_actual_d;
  logic [31:0]          commit_count_q, commit_count_d;
  logic [15:0]          error_count_q, error_count_d;

  logic [IDX_W-1:0]     rs1_idx;
  logic [IDX_W-1:0]     instr_rd;
  logic [WORD_SIZE-1:0] rs1_val;
  logic [WORD_SIZE-1:0] alu_result;
  logic                 alu_illegal;
  logic                 commit_err;
  err_code_e            commit_code;

  // Index 0 is hardwired to zero and never written
  function automatic logic idx_writable(input logic [IDX_W-1:0] idx);
    return (idx != '0) && (32'(idx) < 32'(NUM_REGS));
  endfunction

  assign rs1_idx  = commit_instr[19:15];
  assign instr_rd = commit_instr[11:7];
  assign rs1_val  = idx_writable(rs1_idx) ? shadow_q[rs1_idx] : '0;

  itype_alu_ref #(
    .WORD_SIZE (WORD_SIZE)
  ) u_alu_ref (
    .opcode    (commit_instr[6:0]),
    .funct3    (commit_instr[14:12]),
    .imm12     (commit_instr[31:20]),
    .rs1_val   (rs1_val),
    .result_c  (alu_result),
    .illegal_c (alu_illegal)
  );

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    err_valid_d    = 1'b0;
    err_code_d     = err_code_q;
    err_expected_d = err_expected_q;
    err_actual_d   = err_actual_q;
    commit_count_d = commit_count_q;
    error_count_d  = error_count_q;
    commit_err     = 1'b0;
    commit_code    = ERR_DATA;

    case (state_q)
      ST_INIT: begin
        if (init_we && idx_writable(init_idx)) shadow_d[init_idx] = init_data;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (commit_valid) begin
          commit_count_d = commit_count_q + 32'd1;
          if (alu_illegal) begin
            commit_err  = 1'b1;
            commit_code = ERR_ILLEGAL;
          end else if (commit_rd != instr_rd) begin
            commit_err  = 1'b1;
            commit_code = ERR_RD;
          end else begin
            // Shadow follows the checker's value so later commits stay aligned
            if (idx_writable(commit_rd)) shadow_d[commit_rd] = alu_result;
            if ((commit_rd != '0) && (commit_wdata != alu_result)) begin
              commit_err  = 1'b1;
              commit_code = ERR_DATA;
            end
          end
          if (commit_err) begin
            err_valid_d    = 1'b1;
            err_code_d     = commit_code;
            err_expected_d = alu_result;
            err_actual_d   = commit_wdata;
            if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
            if (STOP_ON_ERR) state_d = ST_FAIL;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_INIT;
      shadow_q       <= '{default: '0};
      err_valid_q    <= 1'b0;
      err_code_q     <= ERR_DATA;
      err_expected_q <= '0;
      err_actual_q   <= '0;
      commit_count_q <= '0;
      error_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      err_valid_q    <= err_valid_d;
      err_code_q     <= err_code_d;
      err_expected_q <= err_expected_d;
      err_actual_q   <= err_actual_d;
      commit_count_q <= commit_count_d;
      error_count_q  <= error_count_d;
    end
  end

  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_expected = err_expected_q;
  assign err_actual   = err_actual_q;
  assign commit_count = commit_count_q;
  assign error_count  = error_count_q;
  assign state        = state_q;

endmodule
